mux_array_multiplier: RTL and testbench
=======================================

// Module: mux_array_multiplier
// PURPOSE
//  Unsigned SIZExSIZE array multiplier: p = x * y, exact, 2*SIZE-bit result.
//  Core: gate-level array of partial-product/carry-save cells, then a chain of
//    2-bit carry-lookahead adders and one final full adder.
//  Core is wrapped in a one-stage output register with a valid flag.
//  Leaf arithmetic block, instantiated by datapath units that need a small fixed-width product.
// PARAMETERS
//  SIZE  4  operand width in bits; legal range SIZE >= 3
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  in_valid   in   1          x/y are a valid operand pair this cycle
//  x          in   SIZE       multiplicand, unsigned
//  y          in   SIZE       multiplier, unsigned
//  out_valid  out  1          p holds the product of an accepted pair
//  p          out  2*SIZE     registered product, unsigned
// BEHAVIOUR
//  Reset is synchronous, active-low. On a clk edge with rst_n=0:
//    - p <= 0
//    - out_valid <= 0
//    - rst_n takes priority over in_valid on the same edge.
//  Latency is exactly 1 cycle. On a clk edge with rst_n=1:
//    - out_valid <= in_valid.
//    - If in_valid=1: p <= x*y, computed from the x/y present before that edge.
//    - If in_valid=0: p holds its previous value.
//  No back-pressure. A new pair can be accepted every cycle (throughput 1/cycle).
//  Arithmetic:
//    - Purely unsigned, full precision; no overflow or truncation possible.
//    - (2^SIZE-1)^2 fits in 2*SIZE bits.
//  Core datapath is combinational with no internal state.
//    - x*y must be correct for every one of the 2^(2*SIZE) input pairs.
//    - The behavioural '*' operator is not used; the product is built from the cell array.
//  Reset mid-stream: a pair accepted on the same edge that reset is asserted is discarded.
//  Output after reset release: out_valid stays 0 until the first in_valid edge with rst_n=1.
// STRUCTURE
//  Package mult_pkg holds only the SIZE-derived widths: PW = 2*SIZE, and NSTEP = SIZE-2.
//  Core array, built with generate loops over step = 0..SIZE-3:
//    - Bit p[0]: x0&y0.
//    - Bit p[1]: from the first sum cell.
//    - Each step adds two product bits, p[2*step+2] and p[2*step+3], through one 2-bit
//      carry-lookahead stage. That stage has carry-in from the previous stage, and
//      carry-in = 0 for step 0.
//    - Top bits p[2*SIZE-2] and p[2*SIZE-1] come from a full adder fed by the last
//      cell's sum, the last cell's product term, and the final lookahead carry.
//  Cells compute AND-based partial products with sum/carry propagation. Mux-based
//    realisation of each cell is permitted.
//  Natural sub-module: mult_cla2, a 2-bit carry-lookahead adder:
//    - Inputs: a[1:0], b[1:0], cin.
//    - Outputs: s[1:0], cout.
//  All cells plus the output register live in this file.
// TESTING
//  - Exhaustive, SIZE=4 and SIZE=5: drive every {x,y} with in_valid=1; compare p to x*y one cycle later.
//    All 256 (SIZE=4) and 1024 (SIZE=5) pairs must match.
//  - Corners, SIZE=4:
//      - 0*0 -> 0
//      - 15*1 -> 15
//      - 1*15 -> 15
//      - 15*15 -> 225 (0xE1)
//      - 8*8 -> 64
//  - Back-to-back: pairs 3*5, 7*9, 15*15 on consecutive cycles.
//    Expect p = 15, 63, 225 on the next three cycles, with out_valid=1 throughout.
//  - Hold: after 6*7 (p=42), drop in_valid and change x,y.
//    Expect p stays 42 and out_valid=0.
//  - Reset: rst_n=0 for one edge while in_valid=1, x=9, y=9.
//    Expect p=0 and out_valid=0; the next valid pair produces a correct product.
//  - SIZE=3 build: 7*7 -> 49 and 5*6 -> 30.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Width helpers derived from the multiplier operand size.
//             PW    = 2*SIZE  (product width)
//             NSTEP = SIZE-2  (number of 2-bit lookahead merge stages)
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Product width for a SIZE x SIZE unsigned multiply
  function automatic int mult_pw(input int size);
    return 2 * size;
  endfunction

  // Number of 2-bit carry-lookahead stages between p[1] and the top full adder
  function automatic int mult_nstep(input int size);
    return size - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_cla2.sv
`default_nettype none
// ============================================================================
//  Module   : mult_cla2
//  Purpose  : 2-bit carry-lookahead adder, s = a + b + cin, cout = carry out.
//             Both carries are formed directly from generate/propagate terms,
//             so a chain of these stages ripples only once per two bits.
//  Revision : 1.0  initial release
// ============================================================================
module mult_cla2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] gen;
  logic [1:0] prop;
  logic       c1;

  // Generate/propagate terms, lookahead carries and sum bits
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    c1   = gen[0] | (prop[0] & cin);
    cout = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    s[0] = prop[0] ^ cin;
    s[1] = prop[1] ^ c1;
  end

endmodule
`default_nettype wire

// File: rtl/mux_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : mux_array_multiplier
//  Purpose  : Unsigned SIZE x SIZE array multiplier with a one-cycle
//             registered output and valid flag.
//             Partial products are reduced by a carry-save array of
//             mux-based full-adder cells (one row per multiplier bit).  The
//             resulting sum/carry vectors are merged by a chain of 2-bit
//             carry-lookahead stages and one final full adder at the top.
//  Revision : 1.0  initial release
// ============================================================================
module mux_array_multiplier
  import mult_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SIZE-1:0]     x,
  input  logic [SIZE-1:0]     y,
  output logic                out_valid,
  output logic [2*SIZE-1:0]   p
);

  localparam int PW    = mult_pw(SIZE);
  localparam int NSTEP = mult_nstep(SIZE);

  // Mux-based full-adder cell; 'a' steers the mux.  Returns {carry, sum}.
  //   a=0 : sum = b^c,    carry = b&c
  //   a=1 : sum = ~(b^c), carry = b|c
  function automatic logic [1:0] mux_fa(input logic a, input logic b, input logic c);
    logic t;
    t = b ^ c;
    return {(a ? (b | c) : (b & c)), (a ? ~t : t)};
  endfunction

  // --------------------------------------------------------------------------
  // Carry-save array.  Each row holds a sum vector and a carry vector indexed
  // by bit weight.  Row i adds partial-product row x*y[i] (weights i..i+SIZE-1)
  // to the previous row's vectors; a cell at weight w emits its carry at w+1.
  // Row i-1 only holds carries at weights i..i+SIZE-1, which row i consumes
  // exactly, so the carry vector of every row is fully accounted for.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    logic [PW-1:0] sum_r;
    logic [PW-1:0] car_r;
    logic [PW-1:0] cell_c;
    logic          unused_row;

    if (i == 0) begin : g_first
      // First row is just the partial products of y[0]; nothing to add yet
      assign sum_r  = {{SIZE{1'b0}}, (x & {SIZE{y[0]}})};
      assign car_r  = '0;
      assign cell_c = '0;
    end else begin : g_add
      for (genvar w = 0; w < PW; w++) begin : g_col
        if ((w >= i) && (w <= i + SIZE - 1)) begin : g_cell
          logic       pp;
          logic [1:0] fa;
          assign pp        = y[i] ? x[w-i] : 1'b0;
          assign fa        = mux_fa(pp, g_row[i-1].sum_r[w], g_row[i-1].car_r[w]);
          assign sum_r[w]  = fa[0];
          assign cell_c[w] = fa[1];
        end else begin : g_pass
          // Weights outside this row's span keep the previous sum bit
          assign sum_r[w]  = g_row[i-1].sum_r[w];
          assign cell_c[w] = 1'b0;
        end
      end
      // Cell carries move up one weight
      assign car_r = {cell_c[PW-2:0], 1'b0};
    end

    // Some bits of these vectors are structurally zero and never read
    assign unused_row = ^{sum_r, car_r, cell_c};
  end

  // --------------------------------------------------------------------------
  // Vector merge.  After the last row the sum vector spans weights 0..PW-2
  // and the carry vector spans weights SIZE..PW-1, so bits 0 and 1 are
  // already final.  Weights 2..PW-3 go through the lookahead chain, weight
  // PW-2 through a full adder.  The top bit combines that adder's carry with
  // the carry-vector bit at PW-1; both can never be set together because the
  // full product fits in PW bits, so an XOR is exact.
  // --------------------------------------------------------------------------
  logic [PW-1:0]  fin_sum;
  logic [PW-1:0]  fin_car;
  logic [NSTEP:0] cla_c;
  logic [1:0]     top_fa;
  logic [PW-1:0]  prod;
  logic           unused_fin;

  assign fin_sum  = g_row[SIZE-1].sum_r;
  assign fin_car  = g_row[SIZE-1].car_r;
  assign cla_c[0] = 1'b0;

  assign prod[0] = fin_sum[0];
  assign prod[1] = fin_sum[1];

  for (genvar s = 0; s < NSTEP; s++) begin : g_step
    mult_cla2 u_cla2 (
      .a    (fin_sum[2*s+3:2*s+2]),
      .b    (fin_car[2*s+3:2*s+2]),
      .cin  (cla_c[s]),
      .s    (prod[2*s+3:2*s+2]),
      .cout (cla_c[s+1])
    );
  end

  assign top_fa     = mux_fa(fin_sum[PW-2], fin_car[PW-2], cla_c[NSTEP]);
  assign prod[PW-2] = top_fa[0];
  assign prod[PW-1] = top_fa[1] ^ fin_car[PW-1];

  // Sum MSB and the two low carry bits are always zero
  assign unused_fin = ^{fin_sum[PW-1], fin_car[1:0]};

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [PW-1:0] p_d;
  logic [PW-1:0] p_q;
  logic          out_valid_d;
  logic          out_valid_q;

  // Capture a new product only for accepted pairs; otherwise hold
  always_comb begin
    p_d         = p_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      p_d = prod;
    end
  end

  // Synchronous active-low reset dominates any pair offered on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_array_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_array_multiplier
//  Purpose  : Scoreboard bench for mux_array_multiplier at SIZE = 4, 5, 3.
//             Drivers push expected products; per-instance monitors pop and
//             compare whenever out_valid is high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_array_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, iv5, iv3;
  logic [3:0] x4, y4;
  logic [4:0] x5, y5;
  logic [2:0] x3, y3;
  logic       ov4, ov5, ov3;
  logic [7:0] p4;
  logic [9:0] p5;
  logic [5:0] p3;

  int q4[$];
  int q5[$];
  int q3[$];
  int n_cmp = 0;
  int n_bad = 0;

  mux_array_multiplier #(.SIZE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .x(x4), .y(y4), .out_valid(ov4), .p(p4)
  );
  mux_array_multiplier #(.SIZE(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .x(x5), .y(y5), .out_valid(ov5), .p(p5)
  );
  mux_array_multiplier #(.SIZE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .x(x3), .y(y3), .out_valid(ov3), .p(p3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitors: one per instance, sampling on the falling edge
  always @(negedge clk) begin
    if (ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb4_extra: got p=%0d, want no output", p4);
      end else begin
        chk("sb4_prod", 32'(p4), 32'(q4.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (ov5 === 1'b1) begin
      if (q5.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb5_extra: got p=%0d, want no output", p5);
      end else begin
        chk("sb5_prod", 32'(p5), 32'(q5.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (ov3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb3_extra: got p=%0d, want no output", p3);
      end else begin
        chk("sb3_prod", 32'(p3), 32'(q3.pop_front()));
      end
    end
  end

  task automatic drv4(input bit v, input int a, input int b, input int e);
    @(negedge clk);
    iv4 = v; x4 = 4'(a); y4 = 4'(b);
    if (v && rst_n) q4.push_back(e);
  endtask

  task automatic drv5(input bit v, input int a, input int b, input int e);
    @(negedge clk);
    iv5 = v; x5 = 5'(a); y5 = 5'(b);
    if (v && rst_n) q5.push_back(e);
  endtask

  task automatic drv3(input bit v, input int a, input int b, input int e);
    @(negedge clk);
    iv3 = v; x3 = 3'(a); y3 = 3'(b);
    if (v && rst_n) q3.push_back(e);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    iv4 = 1'b0; iv5 = 1'b0; iv3 = 1'b0;
    x4 = '0; y4 = '0; x5 = '0; y5 = '0; x3 = '0; y3 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst4_p", 32'(p4), 0);
    chk("rst4_valid", 32'(ov4), 0);
    chk("rst5_p", 32'(p5), 0);
    chk("rst5_valid", 32'(ov5), 0);
    chk("rst3_p", 32'(p3), 0);
    chk("rst3_valid", 32'(ov3), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(ov4), 0);

    // Corners, hand-computed
    drv4(1, 0, 0, 0);
    drv4(1, 15, 1, 15);
    drv4(1, 1, 15, 15);
    drv4(1, 15, 15, 225);
    drv4(1, 8, 8, 64);
    drv4(0, 0, 0, 0);

    // Back-to-back burst
    drv4(1, 3, 5, 15);
    drv4(1, 7, 9, 63);
    drv4(1, 15, 15, 225);
    drv4(0, 0, 0, 0);
    chk("b2b_valid_last", 32'(ov4), 1);
    chk("b2b_p_last", 32'(p4), 225);

    // Hold: product stays when in_valid drops and operands change
    drv4(1, 6, 7, 42);
    drv4(0, 11, 13, 0);
    drv4(0, 2, 3, 0);
    chk("hold_p", 32'(p4), 42);
    chk("hold_valid", 32'(ov4), 0);
    drv4(0, 14, 5, 0);
    chk("hold_p2", 32'(p4), 42);

    // Reset with a pair offered on the same edge: pair is discarded
    @(negedge clk);
    rst_n = 1'b0; iv4 = 1'b1; x4 = 4'd9; y4 = 4'd9;
    @(negedge clk);
    chk("midrst_p", 32'(p4), 0);
    chk("midrst_valid", 32'(ov4), 0);
    rst_n = 1'b1; iv4 = 1'b0;
    @(negedge clk);
    chk("postrst_valid", 32'(ov4), 0);
    drv4(1, 9, 9, 81);
    drv4(1, 10, 12, 120);
    drv4(0, 0, 0, 0);

    // Exhaustive SIZE=4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        drv4(1, a, b, a * b);
    drv4(0, 0, 0, 0);

    // Exhaustive SIZE=5
    drv5(1, 31, 31, 961);
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        drv5(1, a, b, a * b);
    drv5(0, 0, 0, 0);

    // SIZE=3 directed plus exhaustive
    drv3(1, 7, 7, 49);
    drv3(1, 5, 6, 30);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        drv3(1, a, b, a * b);
    drv3(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("q4_drained", 32'(q4.size()), 0);
    chk("q5_drained", 32'(q5.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
